// File: rtl/imem_block_responder.sv
// rtl/imem_block_responder.sv - instruction-memory block responder for I-cache refills
module imem_block_responder #(
    parameter int    DEPTH_BLOCKS = 256,
    parameter int    LATENCY      = 4,
    parameter string INIT_FILE    = ""
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         READ,
    input  logic [27:0]  ADDR,
    output logic         BUSYWAIT,
    output logic [127:0] READ_DATA,
    input  logic         PROG_WE,
    input  logic [31:0]  PROG_ADDR,
    input  logic [31:0]  PROG_DATA
);

    localparam int IDX_W = $clog2(DEPTH_BLOCKS);
    localparam int WORDS = DEPTH_BLOCKS * 4;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t             state;
    logic [27:0]        req_addr;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        mem [WORDS];

    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W+1:0]   prog_word;
    logic [127:0]       blk_data;
    logic               unused_prog_bits;

    // Block index uses only the low address bits, so larger addresses alias.
    assign rd_idx    = req_addr[IDX_W-1:0];
    assign prog_word = {PROG_ADDR[IDX_W+3:4], PROG_ADDR[3:2]};
    assign blk_data  = {mem[{rd_idx, 2'd3}], mem[{rd_idx, 2'd2}],
                        mem[{rd_idx, 2'd1}], mem[{rd_idx, 2'd0}]};
    assign unused_prog_bits = ^{PROG_ADDR[31:IDX_W+4], PROG_ADDR[1:0]};

    // Program-port word write; the array is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (PROG_WE) begin
            mem[prog_word] <= PROG_DATA;
        end
    end

    // Request FSM: latch address, count down latency, deliver block, hold it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            req_addr  <= '0;
            cnt       <= '0;
            READ_DATA <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (READ) begin
                        req_addr <= ADDR;
                        cnt      <= CNT_LOAD;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!READ) begin
                        state <= ST_IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // Array read uses pre-write contents if a program write lands this edge.
                        READ_DATA <= blk_data;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!READ) begin
                        state <= ST_IDLE;
                    end else if (ADDR != req_addr) begin
                        req_addr <= ADDR;
                        cnt      <= CNT_LOAD;
                        state    <= ST_WAIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Busy is combinational so the requester stalls in the same cycle it asks.
    always_comb begin
        BUSYWAIT = 1'b0;
        if (!RESET) begin
            case (state)
                ST_IDLE: BUSYWAIT = READ;
                ST_WAIT: BUSYWAIT = 1'b1;
                ST_DONE: BUSYWAIT = READ && (ADDR != req_addr);
                default: BUSYWAIT = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_block_responder.sv
// tb/tb_imem_block_responder.sv - self-checking bench for imem_block_responder
module tb_imem_block_responder;

    logic         clk;
    logic         rst;
    logic         rd0, rd1;
    logic [27:0]  ad0, ad1;
    logic         busy0, busy1;
    logic [127:0] rdata0, rdata1;
    logic         pwe;
    logic [31:0]  paddr, pdata;

    int total = 0;
    int bad   = 0;

    logic [127:0] exp_q[$];

    typedef struct {
        logic [27:0]  addr;
        logic [127:0] data;
    } vec_t;

    localparam logic [127:0] BLK0  = 128'hA0000003_A0000002_A0000001_A0000000;
    localparam logic [127:0] BLK1  = 128'h00000004_00000003_00000002_00000001;
    localparam logic [127:0] BLK2  = 128'h22220003_22220002_22220001_22220000;
    localparam logic [127:0] BLKFF = 128'hFFFF0003_FFFF0002_FFFF0001_FFFF0000;
    localparam logic [127:0] BLK1N = 128'h00000004_DEADBEEF_00000002_00000001;

    imem_block_responder #(.DEPTH_BLOCKS(256), .LATENCY(4)) dut0 (
        .CLK(clk), .RESET(rst), .READ(rd0), .ADDR(ad0), .BUSYWAIT(busy0),
        .READ_DATA(rdata0), .PROG_WE(pwe), .PROG_ADDR(paddr), .PROG_DATA(pdata)
    );

    imem_block_responder #(.DEPTH_BLOCKS(256), .LATENCY(1)) dut1 (
        .CLK(clk), .RESET(rst), .READ(rd1), .ADDR(ad1), .BUSYWAIT(busy1),
        .READ_DATA(rdata1), .PROG_WE(pwe), .PROG_ADDR(paddr), .PROG_DATA(pdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [31:0] a, input logic [31:0] d);
        pwe = 1'b1; paddr = a; pdata = d;
        tick();
        pwe = 1'b0;
    endtask

    function automatic logic busy_of(input bit sel);
        return sel ? busy1 : busy0;
    endfunction

    function automatic logic [127:0] data_of(input bit sel);
        return sel ? rdata1 : rdata0;
    endfunction

    // Full request from IDLE: expects busy at once, LATENCY+1 sampled edges, data held after READ drops.
    task automatic read_block(input bit sel, input logic [27:0] a, input logic [127:0] exp, input int lat_cfg);
        int edges;
        logic [127:0] want;
        exp_q.push_back(exp);
        if (sel) begin rd1 = 1'b1; ad1 = a; end
        else     begin rd0 = 1'b1; ad0 = a; end
        #1;
        chk("busy_on_request", 128'(busy_of(sel)), 128'(1));
        edges = 0;
        while (busy_of(sel) && edges < 64) begin
            tick();
            edges++;
        end
        chk("latency_edges", 128'(edges), 128'(lat_cfg + 1));
        want = exp_q.pop_front();
        chk("block_data", data_of(sel), want);
        if (sel) rd1 = 1'b0; else rd0 = 1'b0;
        tick();
        chk("data_held_after_drop", data_of(sel), want);
        chk("idle_not_busy", 128'(busy_of(sel)), 128'(0));
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{addr: 28'h0000001, data: BLK1};
        vecs[1] = '{addr: 28'h0000002, data: BLK2};
        vecs[2] = '{addr: 28'h00000FF, data: BLKFF};
        vecs[3] = '{addr: 28'h0000000, data: BLK0};
        vecs[4] = '{addr: 28'h0000101, data: BLK1};
        vecs[5] = '{addr: 28'hFFFFFFF, data: BLKFF};

        rd0 = 1'b0; rd1 = 1'b0; ad0 = '0; ad1 = '0;
        pwe = 1'b0; paddr = '0; pdata = '0;

        // Reset state, with READ high to show busy is forced low during reset.
        rst = 1'b1;
        rd0 = 1'b1;
        repeat (2) tick();
        chk("reset_busy_forced_low", 128'(busy0), 128'(0));
        chk("reset_read_data", rdata0, 128'(0));
        chk("reset_read_data_lat1", rdata1, 128'(0));
        rd0 = 1'b0;
        rst = 1'b0;
        tick();
        chk("idle_no_request", 128'(busy0), 128'(0));

        // Preload; block 2 uses nonzero byte offsets to show PROG_ADDR[1:0] is ignored.
        for (int w = 0; w < 4; w++) begin
            prog(32'h0000_0000 + 32'(w * 4), 32'hA000_0000 + 32'(w));
            prog(32'h0000_0010 + 32'(w * 4), 32'(w + 1));
            prog(32'h0000_0020 + 32'(w * 4) + 32'(w), 32'h2222_0000 + 32'(w));
            prog(32'h0000_0FF0 + 32'(w * 4), 32'hFFFF_0000 + 32'(w));
        end

        // Table-driven reads, including last block and aliased addresses.
        for (int i = 0; i < 6; i++) begin
            read_block(1'b0, vecs[i].addr, vecs[i].data, 4);
        end

        // LATENCY=1 build.
        read_block(1'b1, 28'h0000001, BLK1, 1);
        read_block(1'b1, 28'h0000002, BLK2, 1);

        // Abort after two sampled edges: data from last read (block 0xFF) must remain.
        rd0 = 1'b1; ad0 = 28'h0000002;
        tick(); tick();
        rd0 = 1'b0;
        #1;
        chk("abort_busy_in_wait", 128'(busy0), 128'(1));
        tick();
        chk("abort_busy_low", 128'(busy0), 128'(0));
        chk("abort_data_unchanged", rdata0, BLKFF);
        repeat (5) tick();
        chk("abort_no_late_data", rdata0, BLKFF);

        // Back-to-back: stay in DONE, switch address with READ held high.
        rd0 = 1'b1; ad0 = 28'h0000001;
        repeat (5) tick();
        chk("b2b_first_done", 128'(busy0), 128'(0));
        chk("b2b_first_data", rdata0, BLK1);
        ad0 = 28'h0000002;
        #1;
        chk("b2b_busy_same_cycle", 128'(busy0), 128'(1));
        chk("b2b_data_still_old", rdata0, BLK1);
        begin
            int edges = 0;
            exp_q.push_back(BLK2);
            while (busy0 && edges < 64) begin
                tick();
                edges++;
            end
            chk("b2b_latency_edges", 128'(edges), 128'(5));
            chk("b2b_second_data", rdata0, exp_q.pop_front());
        end
        rd0 = 1'b0;
        tick();
        chk("b2b_held_1", rdata0, BLK2);
        tick();
        chk("b2b_held_2", rdata0, BLK2);

        // Program write to block 1 word 2 on the completing edge returns the old word.
        rd0 = 1'b1; ad0 = 28'h0000001;
        repeat (4) tick();
        chk("wr_race_still_busy", 128'(busy0), 128'(1));
        pwe = 1'b1; paddr = 32'h0000_0018; pdata = 32'hDEAD_BEEF;
        tick();
        pwe = 1'b0;
        chk("wr_race_done", 128'(busy0), 128'(0));
        chk("wr_race_old_word", rdata0, BLK1);
        rd0 = 1'b0;
        tick();
        read_block(1'b0, 28'h0000001, BLK1N, 4);

        // Reset during WAIT aborts; array contents survive.
        rd0 = 1'b1; ad0 = 28'h0000002;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("rst_wait_busy_low", 128'(busy0), 128'(0));
        chk("rst_wait_data_zero", rdata0, 128'(0));
        rd0 = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        read_block(1'b0, 28'h0000001, BLK1N, 4);
        read_block(1'b0, 28'h0000002, BLK2, 4);

        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
